// File: rtl/ddr_rr_scheduler.sv
// Three-requester round-robin front end for a single-outstanding DDR port.
// Handshake: req_ready[g] is a combinational one-hot grant valid only in IDLE; a transfer happens when req_valid[g] && req_ready[g].
module ddr_rr_scheduler #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 512,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [3*ADDR_W-1:0] req_index,
  input  logic [2:0]          req_write,
  input  logic [3*DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [2:0]          resp_done,
  output logic                ddr_chip_enable,
  output logic [ADDR_W-1:0]   ddr_index,
  output logic                ddr_write_enable,
  output logic                ddr_burst_mode,
  output logic [DATA_W-1:0]   ddr_write_data,
  input  logic [DATA_W-1:0]   ddr_read_data,
  input  logic                ddr_operation_done,
  input  logic                ddr_ready,
  output logic                busy,
  output logic                timeout_err,
  output logic [1:0]          dbg_state
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 10) ? $clog2(TIMEOUT_CYC + 1) : 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               terr_q, terr_d;
  logic [2:0]         done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               wr_q, wr_d;
  logic [DATA_W-1:0]  wd_q, wd_d;

  logic               any_valid;
  logic [1:0]         win;
  logic [1:0]         cand;

  // Scan ptr, ptr+1, ptr+2 (mod 3) and take the first valid requester.
  always_comb begin
    any_valid = 1'b0;
    win       = ptr_q;
    cand      = '0;
    for (int k = 0; k < 3; k++) begin
      cand = 2'((int'(ptr_q) + k) % 3);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    terr_d          = terr_q;
    done_d          = '0;
    rdata_d         = rdata_q;
    idx_d           = idx_q;
    wr_d            = wr_q;
    wd_d            = wd_q;
    req_ready       = '0;
    ddr_chip_enable = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          req_ready = 3'(3'b001 << win);
          owner_d   = win;
          idx_d     = req_index[win*ADDR_W +: ADDR_W];
          wr_d      = req_write[win];
          wd_d      = req_wdata[win*DATA_W +: DATA_W];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ddr_chip_enable = ddr_ready;
        if (ddr_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A real completion takes priority over a watchdog expiry in the same cycle.
        if (ddr_operation_done) begin
          rdata_d = wr_q ? '0 : ddr_read_data;
          done_d  = 3'(3'b001 << owner_q);
          ptr_d   = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          terr_d  = 1'b1;
          rdata_d = '0;
          done_d  = 3'(3'b001 << owner_q);
          ptr_d   = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flops clear asynchronously, but the grant path is combinational and must also drop.
    if (reset) req_ready = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      done_q  <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
    end
  end

  assign resp_rdata       = rdata_q;
  assign resp_done        = done_q;
  assign ddr_index        = idx_q;
  assign ddr_write_enable = wr_q;
  assign ddr_burst_mode   = ~wr_q;
  assign ddr_write_data   = wd_q;
  assign busy             = (state_q != S_IDLE);
  assign timeout_err      = terr_q;
  assign dbg_state        = state_q;

endmodule
